// File: rtl/nested_loop_sequencer.sv
// nested_loop_sequencer
//   Sequential replacement for a combinational nested while-loop iteration
//   counter. Walks i over 0..outer_limit-1 and, for each i, j over
//   1..inner_limit. Each (i,j) pair is offered as one beat on a valid/ready
//   stream. One programmable (i,j) "continue" point can be skipped.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               launch a sequence (sampled in IDLE only)
//   outer_limit         outer trip count, latched on accepted start
//   inner_limit         inner trip count, latched on accepted start
//   skip_en/i/j         skip point, latched on accepted start
//   iter_ready          downstream accepts the presented iteration
//   iter_valid          iteration (iter_i, iter_j) presented
//   iter_i, iter_j      presented outer / inner (post-increment) index
//   busy                high while the sequence runs
//   done                one-cycle pulse at sequence end
//   count               executed-iteration count, holds until next start
module nested_loop_sequencer #(
    parameter int IW = 2,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [IW-1:0] outer_limit,
    input  logic [IW-1:0] inner_limit,
    input  logic          skip_en,
    input  logic [IW-1:0] skip_i,
    input  logic [IW-1:0] skip_j,
    input  logic          iter_ready,
    output logic          iter_valid,
    output logic [IW-1:0] iter_i,
    output logic [IW-1:0] iter_j,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IW:0]   IONE = (IW+1)'(1);
    localparam logic [CW-1:0] CONE = CW'(1);

    state_t        state;
    logic [IW-1:0] i, j;
    logic [IW-1:0] lim_o, lim_i;
    logic          sk_en;
    logic [IW-1:0] sk_i, sk_j;

    // Next indices are formed one bit wider so i+1 / j+1 never wrap
    // before being compared against the limits.
    logic [IW:0] jn, inx;
    logic        run, skip_hit, retire;

    always_comb begin
        jn       = {1'b0, j} + IONE;
        inx      = {1'b0, i} + IONE;
        run      = (state == RUN);
        skip_hit = sk_en && (i == sk_i) && (jn == {1'b0, sk_j});
        // A skipped candidate retires on its own; others need the handshake.
        retire   = run && (skip_hit || iter_ready);
    end

    assign iter_valid = run && !skip_hit;
    assign iter_i     = run ? i : '0;
    assign iter_j     = run ? jn[IW-1:0] : '0;
    assign busy       = run;
    assign done       = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            lim_o <= '0;
            lim_i <= '0;
            sk_en <= 1'b0;
            sk_i  <= '0;
            sk_j  <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        lim_o <= outer_limit;
                        lim_i <= inner_limit;
                        sk_en <= skip_en;
                        sk_i  <= skip_i;
                        sk_j  <= skip_j;
                        count <= '0;
                        i     <= '0;
                        j     <= '0;
                        if (outer_limit != '0 && inner_limit != '0)
                            state <= RUN;
                        else
                            state <= DONE;
                    end
                end
                RUN: begin
                    if (retire) begin
                        if (!skip_hit)
                            count <= count + CONE;
                        if (jn < {1'b0, lim_i}) begin
                            j <= jn[IW-1:0];
                        end else begin
                            j <= '0;
                            i <= inx[IW-1:0];
                            if (inx == {1'b0, lim_o})
                                state <= DONE;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
